// File: rtl/eth_tx_sequencer.sv
// MMIO write initiator for the Ethernet transmit path: programs the UDP header registers,
// copies the payload into SEND_BUF word by word (with byte/halfword tails), then fires SEND_TRIGGER.
module eth_tx_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          BUF_SIZE  = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_dest_ip,
  input  logic [15:0] i_src_port,
  input  logic [15:0] i_dest_port,
  input  logic [15:0] i_length,
  output logic        o_pl_re,
  output logic [15:0] o_pl_addr,
  input  logic [31:0] i_pl_data,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [31:0] o_data,
  output logic [1:0]  o_mem_size,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);
  // state    | meaning
  // IDLE     | ready for a request
  // ERR      | oversize request rejected, o_err pulse
  // CFG_*    | one config register write each
  // FETCH    | payload word read strobe
  // COPY     | SEND_BUF write (two cycles for a 3-byte tail)
  // TRIG     | SEND_TRIGGER write
  // DONE     | o_done pulse, bus idle
  localparam logic [15:0] BUF_BYTES = 16'(BUF_SIZE / 8);

  typedef enum logic [3:0] {
    S_IDLE, S_ERR, S_CFG_IP, S_CFG_SP, S_CFG_DP, S_CFG_LEN,
    S_FETCH, S_COPY, S_TRIG, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_ip;
  logic [15:0] r_sp, r_dp, r_len;
  logic [13:0] r_widx;
  logic        r_hi;
  logic [7:0]  r_tail_b;

  logic        w_accept, w_tail, w_more;
  logic [1:0]  w_rem;
  logic [13:0] w_nw;
  logic [31:0] w_buf_addr;

  assign w_rem      = r_len[1:0];
  assign w_nw       = r_len[15:2];
  assign w_accept   = (r_state == S_IDLE) && i_req_valid;
  assign w_tail     = (r_widx == w_nw);
  assign w_more     = ((r_widx + 14'd1) < w_nw) || (w_rem != 2'd0);
  assign w_buf_addr = BASE_ADDR + 32'h0000_1000 + {16'b0, r_widx, 2'b00};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ip     <= '0;
      r_sp     <= '0;
      r_dp     <= '0;
      r_len    <= '0;
      r_widx   <= '0;
      r_hi     <= 1'b0;
      r_tail_b <= '0;
    end else begin
      if (w_accept) begin
        r_ip   <= i_dest_ip;
        r_sp   <= i_src_port;
        r_dp   <= i_dest_port;
        r_len  <= i_length;
        r_widx <= '0;
        r_hi   <= 1'b0;
      end
      if (r_state == S_COPY) begin
        if (!w_tail)
          r_widx <= r_widx + 14'd1;
        else if (w_rem == 2'd3 && !r_hi)
          r_hi <= 1'b1;
        // upper byte of a 3-byte tail is written one cycle after the read data goes away
        if (!r_hi) r_tail_b <= i_pl_data[23:16];
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    o_busy      = 1'b1;
    o_pl_re     = 1'b0;
    o_pl_addr   = '0;
    o_we        = 1'b0;
    o_addr      = '0;
    o_data      = '0;
    o_mem_size  = 2'b00;
    o_done      = 1'b0;
    o_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_req_valid) w_next = (i_length > BUF_BYTES) ? S_ERR : S_CFG_IP;
      end
      S_ERR: begin
        o_err  = 1'b1;
        w_next = S_IDLE;
      end
      S_CFG_IP: begin
        o_we   = 1'b1;
        o_addr = BASE_ADDR + 32'h10;
        o_data = r_ip;
        w_next = S_CFG_SP;
      end
      S_CFG_SP: begin
        o_we       = 1'b1;
        o_addr     = BASE_ADDR + 32'h14;
        o_data     = {16'b0, r_sp};
        o_mem_size = 2'b01;
        w_next     = S_CFG_DP;
      end
      S_CFG_DP: begin
        o_we       = 1'b1;
        o_addr     = BASE_ADDR + 32'h16;
        o_data     = {16'b0, r_dp};
        o_mem_size = 2'b01;
        w_next     = S_CFG_LEN;
      end
      S_CFG_LEN: begin
        o_we       = 1'b1;
        o_addr     = BASE_ADDR + 32'h18;
        o_data     = {16'b0, r_len};
        o_mem_size = 2'b01;
        w_next     = (r_len == 16'd0) ? S_TRIG : S_FETCH;
      end
      S_FETCH: begin
        o_pl_re   = 1'b1;
        o_pl_addr = {2'b00, r_widx};
        w_next    = S_COPY;
      end
      S_COPY: begin
        o_we   = 1'b1;
        o_addr = w_buf_addr;
        w_next = S_TRIG;
        if (!w_tail) begin
          o_data = i_pl_data;
          w_next = w_more ? S_FETCH : S_TRIG;
        end else begin
          case (w_rem)
            2'd1: begin
              o_data     = {24'b0, i_pl_data[7:0]};
              o_mem_size = 2'b10;
            end
            2'd2: begin
              o_data     = {16'b0, i_pl_data[15:0]};
              o_mem_size = 2'b01;
            end
            default: begin
              if (!r_hi) begin
                o_data     = {16'b0, i_pl_data[15:0]};
                o_mem_size = 2'b01;
                w_next     = S_COPY;
              end else begin
                o_addr     = w_buf_addr + 32'd2;
                o_data     = {24'b0, r_tail_b};
                o_mem_size = 2'b10;
              end
            end
          endcase
        end
      end
      S_TRIG: begin
        o_we       = 1'b1;
        o_addr     = BASE_ADDR + 32'h1A;
        o_data     = 32'd1;
        o_mem_size = 2'b10;
        w_next     = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_tx_sequencer.sv
// Bench for eth_tx_sequencer: a per-cycle expected trace is built from the send rules and
// compared against every DUT output each cycle, plus literal checks on the write log.
module tb_eth_tx_sequencer;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_dest_ip = '0;
  logic [15:0] i_src_port = '0, i_dest_port = '0, i_length = '0;
  logic        o_pl_re;
  logic [15:0] o_pl_addr;
  logic [31:0] i_pl_data = '0;
  logic        o_we;
  logic [31:0] o_addr, o_data;
  logic [1:0]  o_mem_size;
  logic        o_busy, o_done, o_err;

  eth_tx_sequencer dut (
    .i_clk(clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_dest_ip(i_dest_ip), .i_src_port(i_src_port), .i_dest_port(i_dest_port),
    .i_length(i_length), .o_pl_re(o_pl_re), .o_pl_addr(o_pl_addr), .i_pl_data(i_pl_data),
    .o_we(o_we), .o_addr(o_addr), .o_data(o_data), .o_mem_size(o_mem_size),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, c0 = 0, done_cyc = -1000, err_cyc = -1000, re_cnt = 0;
  logic [31:0] pl_mem [64];
  logic [87:0] exp_q[$], tq[$];
  logic [65:0] wlog[$];
  logic [87:0] act;

  assign act = {o_we, o_addr, o_data, o_mem_size, o_pl_re, o_pl_addr,
                o_busy, o_req_ready, o_done, o_err};

  // payload source: one-cycle read latency, garbage when not read
  always @(posedge clk) i_pl_data <= o_pl_re ? pl_mem[o_pl_addr[5:0]] : $urandom();
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [87:0] ev(bit we, bit [31:0] a, bit [31:0] d, bit [1:0] sz,
                                     bit re, bit [15:0] pa, bit busy, bit rdy, bit dn, bit er);
    return {we, a, d, sz, re, pa, busy, rdy, dn, er};
  endfunction
  function automatic logic [87:0] idle_v();
    return ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endfunction
  function automatic logic [87:0] wr(bit [31:0] a, bit [31:0] d, bit [1:0] sz);
    return ev(1, a, d, sz, 0, 0, 1, 0, 0, 0);
  endfunction
  function automatic logic [87:0] fe(int w);
    return ev(0, 0, 0, 0, 1, 16'(w), 1, 0, 0, 0);
  endfunction

  task automatic chk(input string nm, input logic [87:0] a, input logic [87:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (o_we === 1'b1) wlog.push_back({o_addr, o_data, o_mem_size});
    if (o_pl_re === 1'b1) re_cnt++;
    if (o_done === 1'b1) done_cyc = cyc;
    if (o_err === 1'b1) err_cyc = cyc;
    if (exp_q.size() > 0) chk("cycle", act, exp_q.pop_front());
  end

  // expected trace from the accept cycle T0 through the DONE cycle (or the ERR cycle)
  task automatic gen(input logic [31:0] ip, input logic [15:0] sp, dp, len);
    int nw, rem;
    logic [31:0] d, ba;
    tq.delete();
    tq.push_back(idle_v());
    if (len > 128) begin
      tq.push_back(ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
      return;
    end
    tq.push_back(wr(BASE + 32'h10, ip, 2'b00));
    tq.push_back(wr(BASE + 32'h14, {16'b0, sp}, 2'b01));
    tq.push_back(wr(BASE + 32'h16, {16'b0, dp}, 2'b01));
    tq.push_back(wr(BASE + 32'h18, {16'b0, len}, 2'b01));
    nw = int'(len) / 4;
    rem = int'(len) % 4;
    for (int w = 0; w < nw; w++) begin
      tq.push_back(fe(w));
      tq.push_back(wr(BASE + 32'h1000 + 32'(4 * w), pl_mem[w], 2'b00));
    end
    if (rem != 0) begin
      d  = pl_mem[nw];
      ba = BASE + 32'h1000 + 32'(4 * nw);
      tq.push_back(fe(nw));
      if (rem == 1) tq.push_back(wr(ba, d & 32'hFF, 2'b10));
      else if (rem == 2) tq.push_back(wr(ba, d & 32'hFFFF, 2'b01));
      else begin
        tq.push_back(wr(ba, d & 32'hFFFF, 2'b01));
        tq.push_back(wr(ba + 2, (d >> 16) & 32'hFF, 2'b10));
      end
    end
    tq.push_back(wr(BASE + 32'h1A, 32'd1, 2'b10));
    tq.push_back(ev(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    chk("drain_timeout", 88'(exp_q.size()), 88'd0);
    exp_q.delete();
  endtask

  task automatic start_log();
    c0 = cyc; wlog.delete(); re_cnt = 0; done_cyc = -1000; err_cyc = -1000;
  endtask

  // rst_at >= 0: synchronous reset applied during cycle T<rst_at>
  task automatic run(input logic [31:0] ip, input logic [15:0] sp, dp, len, input int rst_at);
    @(posedge clk); #1;
    start_log();
    gen(ip, sp, dp, len);
    if (rst_at >= 0) while (tq.size() > rst_at + 1) void'(tq.pop_back());
    foreach (tq[i]) exp_q.push_back(tq[i]);
    exp_q.push_back(idle_v());
    i_dest_ip = ip; i_src_port = sp; i_dest_port = dp; i_length = len;
    i_req_valid = 1'b1;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    i_dest_ip = $urandom(); i_length = 16'($urandom());
    if (rst_at >= 0) begin
      repeat (rst_at - 1) @(posedge clk);
      #1 i_rst = 1'b1;
      @(posedge clk);
      #1 i_rst = 1'b0;
    end
    drain();
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) pl_mem[i] = $urandom();
  endtask

  initial begin
    int dur1;
    fill_rand();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", act, idle_v());
    @(posedge clk); #1 i_rst = 1'b0;

    pl_mem[0] = 32'h1122_3344; pl_mem[1] = 32'h5566_7788;
    run(32'hC0A8_0102, 16'h1234, 16'h5678, 16'd8, -1);
    chk("len8_done_lat", 88'(done_cyc - c0), 88'd10);
    chk("len8_nwr", 88'(wlog.size()), 88'd7);
    chk("len8_ip", 88'(wlog[0]), {22'b0, 32'h1000_0010, 32'hC0A8_0102, 2'b00});
    chk("len8_w0", 88'(wlog[4]), {22'b0, 32'h1000_1000, 32'h1122_3344, 2'b00});
    chk("len8_w1", 88'(wlog[5]), {22'b0, 32'h1000_1004, 32'h5566_7788, 2'b00});
    chk("len8_trig", 88'(wlog[6]), {22'b0, 32'h1000_001A, 32'h0000_0001, 2'b10});

    pl_mem[0] = 32'hA1B2_C3D4; pl_mem[1] = 32'h9988_7766;
    run(32'h0A00_0001, 16'd1, 16'd2, 16'd7, -1);
    chk("len7_nwr", 88'(wlog.size()), 88'd8);
    chk("len7_hw", 88'(wlog[5]), {22'b0, 32'h1000_1004, 32'h0000_7766, 2'b01});
    chk("len7_byte", 88'(wlog[6]), {22'b0, 32'h1000_1006, 32'h0000_0088, 2'b10});
    chk("len7_done_lat", 88'(done_cyc - c0), 88'd11);

    run(32'h0102_0304, 16'd9, 16'd10, 16'd0, -1);
    chk("len0_done_lat", 88'(done_cyc - c0), 88'd6);
    chk("len0_re_cnt", 88'(re_cnt), 88'd0);
    chk("len0_nwr", 88'(wlog.size()), 88'd5);

    run(32'h0102_0304, 16'd9, 16'd10, 16'd129, -1);
    chk("len129_err_lat", 88'(err_cyc - c0), 88'd1);
    chk("len129_nwr", 88'(wlog.size()), 88'd0);

    fill_rand();
    run(32'hDEAD_BEEF, 16'd3, 16'd4, 16'd128, -1);
    chk("len128_nwr", 88'(wlog.size()), 88'd37);

    pl_mem[0] = 32'h1122_3344; pl_mem[1] = 32'h5566_7788;
    run(32'hC0A8_0102, 16'h1234, 16'h5678, 16'd8, 6);
    chk("rst_nwr", 88'(wlog.size()), 88'd5);
    run(32'h0B0B_0B0B, 16'd77, 16'd88, 16'd5, -1);

    // back-to-back: valid held, fields changed while the first send is in progress
    fill_rand();
    @(posedge clk); #1;
    start_log();
    gen(32'hAAAA_0001, 16'd11, 16'd12, 16'd6);
    dur1 = tq.size();
    foreach (tq[i]) exp_q.push_back(tq[i]);
    gen(32'hBBBB_0002, 16'd21, 16'd22, 16'd5);
    foreach (tq[i]) exp_q.push_back(tq[i]);
    exp_q.push_back(idle_v());
    i_dest_ip = 32'hAAAA_0001; i_src_port = 16'd11; i_dest_port = 16'd12; i_length = 16'd6;
    i_req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_dest_ip = 32'hBBBB_0002; i_src_port = 16'd21; i_dest_port = 16'd22; i_length = 16'd5;
    repeat (dur1 - 2) @(posedge clk);
    #1 i_req_valid = 1'b0;
    drain();
    chk("b2b_len1", 88'(wlog[3]), {22'b0, 32'h1000_0018, 32'h0000_0006, 2'b01});
    chk("b2b_ip2", 88'(wlog[7]), {22'b0, 32'h1000_0010, 32'hBBBB_0002, 2'b00});

    for (int n = 0; n < 14; n++) begin
      fill_rand();
      run($urandom(), 16'($urandom()), 16'($urandom()), 16'($urandom_range(0, 135)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
